// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: funct3 encodings, FSM states, address split.
// Pure declarations, no latency; no flow control of its own.
// Legality and alignment helpers keep the top-level request decode readable.
package dcache_pkg;

    localparam int INDEX_W = 3;
    localparam int TAG_W   = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
        if (is_write)
            return f3 inside {F3_SB, F3_SH, F3_SW};
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        return ((f3[1:0] == 2'b01) && offset[0]) || ((f3[1:0] == 2'b10) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/dcache_align.sv
// Load byte/halfword extract with sign/zero extension and store byte-lane merge.
// Purely combinational, zero latency.
// No flow control; the caller decides when results are used.
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] line_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] store_shifted;
    logic [3:0]  byte_en;

    assign byte_sel      = line_word[{offset, 3'b000} +: 8];
    assign half_sel      = offset[1] ? line_word[31:16] : line_word[15:0];
    assign store_shifted = store_data << {offset, 3'b000};

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data = line_word;
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        byte_en = 4'b0000;
        case (funct3)
            F3_SB:   byte_en = 4'b0001 << offset;
            F3_SH:   byte_en = 4'b0011 << offset;
            F3_SW:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        merged_word = line_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b])
                merged_word[b*8 +: 8] = store_shifted[b*8 +: 8];
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache; DATA_CACHE_STATS_EN adds hit/miss counters.
// Hits complete in the request cycle; misses cost writeback (if dirty) + allocate + one hit cycle.
// busywait stalls the pipeline for a miss; memory side waits on mem_busywait each state.
module data_cache
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [2:0]        cpu_funct3,
    input  logic [7:0]        cpu_address,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              busywait,
    output logic              misaligned,
    output logic              mem_read,
    output logic              mem_write,
    output logic [5:0]        mem_address,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
`ifdef DATA_CACHE_STATS_EN
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
`endif
    input  logic              mem_busywait
);

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_arr  [NUM_LINES];
    logic [31:0]        data_arr [NUM_LINES];
    state_e             state_q, state_d;

    logic req_vld, access_ok, hit, idle, hit_done, fill_done;
    logic [31:0] load_data, merged_word;

    assign idx = cpu_address[2 +: INDEX_W];
    assign tag = cpu_address[2 + INDEX_W +: TAG_W];

    // Conflicting strobes or an illegal funct3 are treated as no request at all.
    assign req_vld    = (cpu_read ^ cpu_write) && f3_legal(cpu_write, cpu_funct3);
    assign misaligned = req_vld && f3_misaligned(cpu_funct3, cpu_address[1:0]);
    assign access_ok  = req_vld && !misaligned;
    assign hit        = valid_q[idx] && (tag_arr[idx] == tag);
    assign idle       = (state_q == ST_IDLE);
    assign hit_done   = idle && access_ok && hit;
    assign fill_done  = (state_q == ST_ALLOCATE) && !mem_busywait;
    assign busywait   = (access_ok && !hit) || !idle;

    dcache_align u_align (
        .funct3      (cpu_funct3),
        .offset      (cpu_address[1:0]),
        .line_word   (data_arr[idx]),
        .store_data  (cpu_writedata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign cpu_readdata = (hit_done && cpu_read) ? load_data : '0;

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_q)
            ST_IDLE: begin
                if (access_ok && !hit)
                    state_d = (valid_q[idx] && dirty_q[idx]) ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_arr[idx], idx};
                mem_writedata = data_arr[idx];
                if (!mem_busywait)
                    state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = cpu_address[7:2];
                if (!mem_busywait)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (hit_done && cpu_write) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits alone gate their use.
    always_ff @(posedge clock) begin
        if (fill_done) begin
            data_arr[idx] <= mem_readdata;
            tag_arr[idx]  <= tag;
        end else if (hit_done && cpu_write) begin
            data_arr[idx] <= merged_word;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_done && !(&hit_count))
                hit_count <= hit_count + CNT_W'(1);
            if (idle && access_ok && !hit && !(&miss_count))
                miss_count <= miss_count + CNT_W'(1);
        end
    end
`else
    // Counter width only matters when statistics are built in.
    if (CNT_W < 1) begin : g_no_stats
    end
`endif

endmodule
